// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets inside the 8-byte window and STATUS bit positions.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   localparam int TXDATA_OFS = 0;
   localparam int STATUS_OFS = 4;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVR   = 3;
   localparam int ST_COUNT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers; DEPTH must be a power of two.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS window, TX FIFO and 8N1 framer.
// Define UART_PARITY_EN to add an even-parity bit (8E1, 11-bit frames).
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int             n            = 32,
   parameter logic [n-1:0]   BASE_ADDR    = 32'hFFFF_0000,
   parameter int             DEPTH        = 4,
   parameter int             CLKS_PER_BIT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         memwrite,
   input  logic [n-1:0] dataadr,
   input  logic [n-1:0] writedata,
   output logic [n-1:0] rdata,
   output logic         sel,
   output logic         txd
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = $clog2(CLKS_PER_BIT);

   uart_state_t   state, state_n;
   logic [DW-1:0] div, div_n;
   logic [2:0]    bitidx, bit_n;
   logic [7:0]    shreg, sh_n;
   logic          txd_n;
   logic          ovr;
   logic          tick;
   logic          pop;
   logic          full, empty;
   logic [7:0]    fdout;
   logic [CW-1:0] count;
   logic [n-1:0]  ofs;
   logic          wr_tx, wr_st, rd_st;
   logic          unused_wdata;
`ifdef UART_PARITY_EN
   logic          par, par_n;
`endif

   // Unsigned offset makes the window test wrap-safe at the top of memory.
   assign ofs          = dataadr - BASE_ADDR;
   assign sel          = (ofs < n'(8));
   assign rd_st        = (ofs == n'(STATUS_OFS));
   assign wr_tx        = memwrite && (ofs == n'(TXDATA_OFS));
   assign wr_st        = memwrite && rd_st;
   assign tick         = (div == DW'(CLKS_PER_BIT - 1));
   assign unused_wdata = ^writedata[n-1:8];

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_tx),
      .pop   (pop),
      .din   (writedata[7:0]),
      .dout  (fdout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      rdata = '0;
      if (rd_st) begin
         rdata[ST_BUSY]          = (state != IDLE);
         rdata[ST_FULL]          = full;
         rdata[ST_EMPTY]         = empty;
         rdata[ST_OVR]           = ovr;
         rdata[ST_COUNT +: CW]   = count;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         div    <= '0;
         bitidx <= '0;
         txd    <= 1'b1;
         ovr    <= 1'b0;
      end else begin
         state  <= state_n;
         div    <= div_n;
         bitidx <= bit_n;
         txd    <= txd_n;
         if (wr_st)
            ovr <= 1'b0;
         else if (wr_tx && full && !pop)
            ovr <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      shreg <= sh_n;
`ifdef UART_PARITY_EN
      par   <= par_n;
`endif
   end

   always_comb begin
      state_n = state;
      div_n   = div + DW'(1);
      bit_n   = bitidx;
      sh_n    = shreg;
      txd_n   = txd;
      pop     = 1'b0;
`ifdef UART_PARITY_EN
      par_n   = par;
`endif
      case (state)
         IDLE: begin
            div_n = '0;
            txd_n = 1'b1;
            pop   = !empty;
         end
         START: if (tick) begin
            state_n = DATA;
            div_n   = '0;
            bit_n   = '0;
            txd_n   = shreg[0];
         end
         DATA: if (tick) begin
            div_n = '0;
            if (bitidx == 3'd7) begin
`ifdef UART_PARITY_EN
               state_n = PARITY;
               txd_n   = par;
`else
               state_n = STOP;
               txd_n   = 1'b1;
`endif
            end else begin
               bit_n = bitidx + 3'd1;
               sh_n  = {1'b0, shreg[7:1]};
               txd_n = shreg[1];
            end
         end
`ifdef UART_PARITY_EN
         PARITY: if (tick) begin
            state_n = STOP;
            div_n   = '0;
            txd_n   = 1'b1;
         end
`endif
         STOP: if (tick) begin
            state_n = IDLE;
            div_n   = '0;
            txd_n   = 1'b1;
            pop     = !empty;
         end
         default: begin
            state_n = IDLE;
            div_n   = '0;
            txd_n   = 1'b1;
         end
      endcase
      // A pop starts the next frame immediately, from IDLE or straight out of STOP.
      if (pop) begin
         state_n = START;
         div_n   = '0;
         bit_n   = '0;
         sh_n    = fdout;
         txd_n   = 1'b0;
`ifdef UART_PARITY_EN
         par_n   = ^fdout;
`endif
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx against a queue-based line model
// (byte queue plus the bit sequence currently on the wire).
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam int          DEPTH = 4;
   localparam int          C     = 16;
`ifdef UART_PARITY_EN
   localparam int          FB    = 11;
`else
   localparam int          FB    = 10;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] rdata;
   logic        sel;
   logic        txd;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   bit         line[$];
   int         cnt;
   bit         ovr;
   bit         cap[$];

   always #5 clk = ~clk;

   mmio_uart_tx #(.n(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .rdata     (rdata),
      .sel       (sel),
      .txd       (txd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      longint la = longint'(a);
      longint lb = longint'(BASE);
      return (la >= lb) && (la < lb + 8);
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] s = 0;
      if (line.size() != 0)    s = s | 32'h1;
      if (q.size() == DEPTH)   s = s | 32'h2;
      if (q.size() == 0)       s = s | 32'h4;
      if (ovr)                 s = s | 32'h8;
      s = s + 32'(q.size()) * 16;
      return s;
   endfunction

   task automatic model_reset();
      q.delete();
      line.delete();
      cnt = 0;
      ovr = 1'b0;
   endtask

   // One clock edge of the line: finish the current bit, start a frame if the
   // line is free, then apply the CPU store.
   task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
      int         qpre;
      bit         popped = 1'b0;
      logic [7:0] b;
      if (line.size() != 0) begin
         cnt++;
         if (cnt == C) begin
            void'(line.pop_front());
            cnt = 0;
         end
      end
      qpre = q.size();
      if (line.size() == 0 && qpre != 0) begin
         b = q.pop_front();
         popped = 1'b1;
         line.push_back(1'b0);
         for (int i = 0; i < 8; i++) line.push_back(b[i]);
`ifdef UART_PARITY_EN
         line.push_back(^b);
`endif
         line.push_back(1'b1);
         cnt = 0;
      end
      if (w && a == BASE) begin
         if (qpre < DEPTH || popped) q.push_back(d[7:0]);
         else ovr = 1'b1;
      end
      if (w && a == BASE + 32'd4) ovr = 1'b0;
   endtask

   task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cap.push_back(txd);
      check("txd", {31'b0, txd}, (line.size() != 0) ? {31'b0, line[0]} : 32'h1);
      check("sel", {31'b0, sel}, {31'b0, in_window(dataadr)});
      check("rdata", rdata, (dataadr == BASE + 32'd4) ? model_status() : 32'h0);
      memwrite  = w;
      dataadr   = a;
      writedata = d;
      @(posedge clk);
      model_step(w, a, d);
   endtask

   task automatic run_until_idle(input int budget);
      int i = 0;
      while (i < budget && (line.size() != 0 || q.size() != 0)) begin
         cycle(1'b0, BASE + 32'd4, 32'h0);
         i++;
      end
      check("drain_in_budget", {31'b0, (line.size() == 0 && q.size() == 0)}, 32'h1);
   endtask

   function automatic int first_start();
      for (int i = 0; i < cap.size(); i++)
         if (cap[i] == 1'b0) return i;
      return -1;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] a5_bits;
      int         f;
      int         r;
      logic [31:0] addr;

      reset     = 1'b0;
      memwrite  = 1'b0;
      dataadr   = BASE + 32'd4;
      writedata = 32'h0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_txd", {31'b0, txd}, 32'h1);
      check("rst_status", rdata, 32'h4);
      check("rst_sel", {31'b0, sel}, 32'h1);
      reset = 1'b1;

      // Single A5 frame: start one edge after the store, LSB first.
      cap.delete();
      cycle(1'b1, BASE, 32'h1234_56A5);
      run_until_idle(2000);
      f = first_start();
      check("start_latency", f, 2);
      a5_bits = 10'b1101001010;
      if (f >= 0) begin
         for (int i = 0; i < 9; i++)
            check($sformatf("a5_bit%0d", i), {31'b0, cap[f + i*C + C/2]}, {31'b0, a5_bits[i]});
`ifdef UART_PARITY_EN
         check("a5_parity", {31'b0, cap[f + 9*C + C/2]}, 32'h0);
`endif
         check("a5_stop", {31'b0, cap[f + (FB-1)*C + C/2]}, 32'h1);
      end

`ifdef UART_PARITY_EN
      cap.delete();
      cycle(1'b1, BASE, 32'h07);
      run_until_idle(2000);
      f = first_start();
      if (f >= 0) begin
         check("p07_parity", {31'b0, cap[f + 9*C + C/2]}, 32'h1);
         check("p07_stop", {31'b0, cap[f + 10*C + C/2]}, 32'h1);
      end
`endif

      // Five stores while the first frame is active: nothing dropped.
      cycle(1'b1, BASE, 32'h11);
      repeat (3) cycle(1'b0, BASE + 32'd4, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, BASE, 32'h20 + i);
         cycle(1'b0, BASE + 32'd4, 32'h0);
      end
      #1 check("five_full_no_ovr", rdata & 32'h7A, 32'h42);
      run_until_idle(5000);
      #1 check("five_done_status", rdata, 32'h4);

      // Six back-to-back stores: the sixth is dropped and overrun sticks.
      for (int i = 0; i < 6; i++) cycle(1'b1, BASE, 32'h40 + i);
      cycle(1'b0, BASE + 32'd4, 32'h0);
      #1 check("ovr_set", (rdata >> 3) & 32'h1, 32'h1);
      check("ovr_count", (rdata >> 4) & 32'h7, 32'h4);
      cycle(1'b1, BASE + 32'd4, 32'h0);
      #1 check("ovr_clear", (rdata >> 3) & 32'h1, 32'h0);
      run_until_idle(5000);

      // Status read during a frame, an out-of-window read, then a reset pulse mid-DATA.
      cycle(1'b1, BASE, 32'h00);
      repeat (3*C) cycle(1'b0, BASE + 32'd4, 32'h0);
      cycle(1'b1, BASE, 32'h5A);
      cycle(1'b0, BASE + 32'd4, 32'h0);
      #1 check("rd_busy", rdata & 32'h1, 32'h1);
      check("rd_count", (rdata >> 4) & 32'h7, 32'h1);
      check("rd_sel", {31'b0, sel}, 32'h1);
      cycle(1'b0, 32'h0000_0010, 32'h0);
      #1 check("other_sel", {31'b0, sel}, 32'h0);
      check("other_rdata", rdata, 32'h0);
      cycle(1'b1, BASE, 32'h77);
      cycle(1'b0, BASE + 32'd4, 32'h0);
      #1 check("pre_rst_txd", {31'b0, txd}, 32'h0);
      #1 reset = 1'b0;
      #1 check("arst_txd", {31'b0, txd}, 32'h1);
      check("arst_status", rdata, 32'h4);
      model_reset();
      #1 reset = 1'b1;
      repeat (3*C) cycle(1'b0, BASE + 32'd4, 32'h0);
      #1 check("post_rst_idle", rdata, 32'h4);

      // Random traffic against the model.
      for (int i = 0; i < 900; i++) begin
         r = $urandom_range(0, 99);
         if (r < 15)
            cycle(1'b1, BASE, $urandom);
         else if (r < 18)
            cycle(1'b1, BASE + 32'd4, $urandom);
         else if (r < 21) begin
            addr = BASE + 32'($urandom_range(1, 7));
            if (addr == BASE + 32'd4) addr = BASE + 32'd5;
            cycle(1'b1, addr, $urandom);
         end else if (r < 26)
            cycle(1'b0, $urandom, 32'h0);
         else
            cycle(1'b0, BASE + 32'd4, 32'h0);
      end
      run_until_idle(5000);
      repeat (4) cycle(1'b0, BASE + 32'd4, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter n, default 32: data/address width, matching the CPU data bus.
REQ-002 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000: base of the 8-byte register window.
REQ-003 SHALL have parameter DEPTH, default 4: TX FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, at least 2.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-007 SHALL have port memwrite  input  1  store strobe from CPU (same signal driving dmem).
REQ-008 SHALL have port dataadr  input  n  store/load byte address from CPU.
REQ-009 SHALL have port writedata  input  n  store data from CPU.
REQ-010 SHALL have port rdata  output  n  status read data, combinational from dataadr.
REQ-011 SHALL have port sel  output  1  high when dataadr is inside the window; used by the top to mux rdata over dmem readdata.
REQ-012 SHALL have port txd  output  1  serial line, registered, idle high.

Function
REQ-013 SHALL treat BASE_ADDR+0 as TXDATA (write-only) and BASE_ADDR+4 as STATUS (read; a write clears the overrun flag); other addresses SHALL be ignored.
REQ-014 SHALL enqueue writedata[7:0] on a rising edge with memwrite=1, dataadr=BASE_ADDR and FIFO not full.
REQ-015 SHALL discard the byte on a TXDATA write when the FIFO is full and not popping that cycle, and SHALL set sticky ovr.
REQ-016 SHALL accept the write when push and pop coincide on a full FIFO; count stays DEPTH.
REQ-017 SHALL drive STATUS rdata = {zeros, count, ovr, empty, full, busy}: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 ovr, bits[4+clog2(DEPTH):4] count.
REQ-018 SHALL drive rdata to 0 when dataadr is not BASE_ADDR+4.
REQ-019 SHALL run the FSM states IDLE -> START -> DATA -> STOP -> IDLE, with PARITY inserted between DATA and STOP when enabled.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop on that edge, load the shift register and enter START; txd goes 0 after that edge.
REQ-021 SHALL, for a byte enqueued at edge k into an empty FIFO with the FSM idle, enter START at edge k+1.
REQ-022 SHALL hold each bit for exactly CLKS_PER_BIT cycles via a divider counter that reloads on every state or bit change.
REQ-023 SHALL send DATA LSB-first, 8 bits, with a 3-bit index; STOP drives 1.
REQ-024 SHALL, when STOP ends with the FIFO non-empty, go directly to START (back-to-back frames, no idle gap).
REQ-025 SHALL use wrap-around read/write pointers modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-026 SHALL, while reset=0, asynchronously force: FSM IDLE, txd=1, FIFO empty (pointers and count 0), ovr=0, divider and bit index 0.
REQ-027 SHALL abort any frame in progress on reset assertion mid-frame; queued bytes are lost; txd returns to 1 immediately.

Configuration
REQ-028 SHALL, with macro UART_PARITY_EN defined, insert a PARITY state sending even parity (XOR of the 8 data bits), giving 11-bit frames.
REQ-029 SHALL, with UART_PARITY_EN undefined, omit the PARITY state and logic entirely, giving 10-bit frames.

Structure
REQ-030 SHALL take from shared package uart_pkg: the state enum typedef (IDLE, START, DATA, PARITY, STOP), register offsets TXDATA_OFS=0 and STATUS_OFS=4, and STATUS bit-position constants.
REQ-031 SHALL instantiate one sub-module, sync_fifo (parameterised width 8, DEPTH), providing push/pop/full/empty/count.

Verification
REQ-032 SHALL cover: reset, then store 8'hA5 to BASE_ADDR -> START next edge; txd bits 0,1,0,1,0,0,1,0,1,1 at CLKS_PER_BIT-cycle intervals.
REQ-033 SHALL cover: 5 stores with DEPTH=4 while the first frame is active -> all 5 bytes sent back-to-back, ovr=0 (first popped before fifth).
REQ-034 SHALL cover: 6 rapid stores with DEPTH=4 -> 6th dropped, STATUS bit3=1; store to BASE_ADDR+4 -> bit3=0.
REQ-035 SHALL cover: load from BASE_ADDR+4 during a frame -> busy=1, count correct, sel=1; load from 32'h0000_0010 -> sel=0, rdata=0.
REQ-036 SHALL cover: reset=0 pulse mid-DATA -> txd=1 immediately, empty=1, no further frame.
REQ-037 SHALL cover: UART_PARITY_EN with 8'h07 -> parity bit 1, 11-bit frame.
